// File: rtl/date_set_ctrl.sv
// Edit/commit front end for the BCD date counter: gates day advance, runs the
// year -> month -> day edit sequence and issues a one-cycle parallel load.
module date_set_ctrl #(
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  input  logic       day_tick,
  input  logic       sw_year,
  input  logic [7:0] cur_year,
  input  logic [7:0] cur_mon,
  input  logic [7:0] cur_day,
  output logic       cnt_en,
  output logic       load,
  output logic [7:0] set_year,
  output logic [7:0] set_mon,
  output logic [7:0] set_day,
  output logic       disp_sel,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int unsigned CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {RUN, S_YEAR, S_MON, S_DAY, COMMIT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] blink_cnt;
  logic [7:0]    cap_year, cap_mon, cap_day;
  logic [7:0]    year_next, mon_next, day_next;
  logic [1:0]    field_next;
  logic          editing;

  function automatic logic [7:0] dmax(input logic [7:0] mon);
    case (mon)
      8'h02:                      dmax = 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: dmax = 8'h30;
      default:                    dmax = 8'h31;
    endcase
  endfunction

  function automatic logic bcd_ok(input logic [7:0] b);
    bcd_ok = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] inc_bcd(input logic [7:0] b);
    if (b[3:0] == 4'd9) inc_bcd = {b[7:4] + 4'd1, 4'd0};
    else                inc_bcd = b + 8'd1;
  endfunction

  always_comb begin
    cap_year = bcd_ok(cur_year) ? cur_year : 8'h00;
    cap_mon  = (bcd_ok(cur_mon) && cur_mon != 8'h00 && cur_mon <= 8'h12) ? cur_mon : 8'h01;
    // valid BCD bytes order the same as their decimal values
    cap_day  = (bcd_ok(cur_day) && cur_day != 8'h00 && cur_day <= dmax(cap_mon)) ? cur_day : 8'h01;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mode_pulse) state_next = S_YEAR;
      S_YEAR:  if (mode_pulse) state_next = S_MON;
      S_MON:   if (mode_pulse) state_next = S_DAY;
      S_DAY:   if (mode_pulse) state_next = COMMIT;
      COMMIT:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    year_next = set_year;
    mon_next  = set_mon;
    day_next  = set_day;
    if (state == RUN && mode_pulse) begin
      year_next = cap_year;
      mon_next  = cap_mon;
      day_next  = cap_day;
    end else if (state == S_MON && mode_pulse) begin
      if (set_day > dmax(set_mon)) day_next = dmax(set_mon);
    end else if (!mode_pulse && inc_pulse) begin
      case (state)
        S_YEAR:  year_next = (set_year == 8'h99) ? 8'h00 : inc_bcd(set_year);
        S_MON:   mon_next  = (set_mon == 8'h12) ? 8'h01 : inc_bcd(set_mon);
        S_DAY:   day_next  = (set_day >= dmax(set_mon)) ? 8'h01 : inc_bcd(set_day);
        default: ;
      endcase
    end
  end

  always_comb begin
    field_next = 2'd0;
    case (state_next)
      S_YEAR:  field_next = 2'd1;
      S_MON:   field_next = 2'd2;
      S_DAY:   field_next = 2'd3;
      default: field_next = 2'd0;
    endcase
  end

  assign editing  = (state == S_YEAR) || (state == S_MON) || (state == S_DAY);
  assign disp_sel = (state == RUN) ? sw_year : (state == S_YEAR);

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt_en     <= 1'b0;
      load       <= 1'b0;
      set_year   <= 8'h00;
      set_mon    <= 8'h01;
      set_day    <= 8'h01;
      edit_field <= 2'd0;
      blink      <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      state      <= state_next;
      cnt_en     <= day_tick & (state == RUN) & ~mode_pulse;
      load       <= (state_next == COMMIT);
      set_year   <= year_next;
      set_mon    <= mon_next;
      set_day    <= day_next;
      edit_field <= field_next;
      if (state_next != state || !editing) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule
